// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register-hazard scoreboard between decode and issue
// Tracks one busy bit per GPR for issued-but-not-written-back writes; stalls on RAW/WAW.
module reg_scoreboard #(
  parameter int REG_NUM   = 32,
  parameter int ADDR_W    = 5,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                reg1_read,
  input  logic [ADDR_W-1:0]   reg1_addr,
  input  logic                reg2_read,
  input  logic [ADDR_W-1:0]   reg2_addr,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                flush,
  output logic                stall,
  output logic                issue,
  output logic [REG_NUM-1:0]  busy_vec,
  output logic [ADDR_W:0]     pending_cnt,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int  PW        = ADDR_W + 1;
  localparam logic BYPASS_EN = (WB_BYPASS != 0);

  logic [REG_NUM-1:0] eff_busy;
  logic [REG_NUM-1:0] next_busy;
  logic [PW-1:0]      next_cnt;
  logic               hazard;
  logic               front_ok;

  // A writeback landing this cycle can release its register early when bypass is on.
  always_comb begin
    eff_busy = busy_vec;
    for (int i = 0; i < REG_NUM; i++) begin
      if (BYPASS_EN && wb_valid && (wb_addr == ADDR_W'(i)))
        eff_busy[i] = 1'b0;
    end
    eff_busy[0] = 1'b0;
  end

  always_comb begin
    hazard = (reg1_read    && eff_busy[reg1_addr])
          || (reg2_read    && eff_busy[reg2_addr])
          || (write_enable && eff_busy[write_addr]);
  end

  assign front_ok = !rst && id_valid && !flush;
  assign stall    = front_ok && hazard;
  assign issue    = front_ok && !hazard;

  // Issue of a new write beats a same-cycle writeback to the same register.
  always_comb begin
    next_busy = busy_vec;
    if (flush) begin
      next_busy = '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (issue && write_enable && (write_addr == ADDR_W'(i)))
          next_busy[i] = 1'b1;
        else if (wb_valid && (wb_addr == ADDR_W'(i)))
          next_busy[i] = 1'b0;
      end
    end
    next_busy[0] = 1'b0;
  end

  always_comb begin
    next_cnt = '0;
    for (int i = 0; i < REG_NUM; i++)
      next_cnt = next_cnt + PW'(next_busy[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec     <= '0;
      pending_cnt  <= '0;
      stall_cycles <= '0;
    end else begin
      busy_vec    <= next_busy;
      pending_cnt <= next_cnt;
      if (stall && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
// Instance a: defaults (bypass on); instance b: no bypass, 4-bit stall counter.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, reg1_read, reg2_read, write_enable, wb_valid, flush;
  logic [4:0]  reg1_addr, reg2_addr, write_addr, wb_addr;

  logic        a_stall, a_issue, b_stall, b_issue;
  logic [31:0] a_busy, b_busy;
  logic [5:0]  a_pend, b_pend;
  logic [15:0] a_sc;
  logic [3:0]  b_sc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_scoreboard u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .reg1_read(reg1_read), .reg1_addr(reg1_addr),
    .reg2_read(reg2_read), .reg2_addr(reg2_addr),
    .write_enable(write_enable), .write_addr(write_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .stall(a_stall), .issue(a_issue), .busy_vec(a_busy),
    .pending_cnt(a_pend), .stall_cycles(a_sc)
  );

  reg_scoreboard #(.WB_BYPASS(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .reg1_read(reg1_read), .reg1_addr(reg1_addr),
    .reg2_read(reg2_read), .reg2_addr(reg2_addr),
    .write_enable(write_enable), .write_addr(write_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .stall(b_stall), .issue(b_issue), .busy_vec(b_busy),
    .pending_cnt(b_pend), .stall_cycles(b_sc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; reg1_read = 0; reg1_addr = 0; reg2_read = 0; reg2_addr = 0;
    write_enable = 0; write_addr = 0; wb_valid = 0; wb_addr = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [4:0] wa);
    idle();
    id_valid = 1; write_enable = 1; write_addr = wa;
    #1;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    id_valid = 1; write_enable = 1; write_addr = 5;
    #1;
    chk("rst_issue", {31'd0, a_issue}, 32'd0);
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    step(); step();
    chk("rst_busy", a_busy, 32'd0);
    chk("rst_pend", {26'd0, a_pend}, 32'd0);
    chk("rst_sc", {16'd0, a_sc}, 32'd0);
    rst = 0;
    idle();
    #1;

    // 1: issue write r5
    id_valid = 1; write_enable = 1; write_addr = 5;
    #1;
    chk("t1_issue", {31'd0, a_issue}, 32'd1);
    chk("t1_stall", {31'd0, a_stall}, 32'd0);
    step();
    idle();
    chk("t1_busy", a_busy, 32'h0000_0020);
    chk("t1_pend", {26'd0, a_pend}, 32'd1);

    // 2: RAW on r5, then bypassed writeback
    id_valid = 1; reg1_read = 1; reg1_addr = 5;
    #1;
    chk("t2_stall", {31'd0, a_stall}, 32'd1);
    chk("t2_issue", {31'd0, a_issue}, 32'd0);
    step();
    chk("t2_sc", {16'd0, a_sc}, 32'd1);
    wb_valid = 1; wb_addr = 5;
    #1;
    chk("t2_byp_stall", {31'd0, a_stall}, 32'd0);
    chk("t2_byp_issue", {31'd0, a_issue}, 32'd1);
    chk("t2_nobyp_stall", {31'd0, b_stall}, 32'd1);
    step();
    idle();
    chk("t2_busy", a_busy, 32'd0);
    chk("t2_b_sc", {28'd0, b_sc}, 32'd2);

    // 3: issue vs same-cycle wb to r7, then write r0
    id_valid = 1; write_enable = 1; write_addr = 7; wb_valid = 1; wb_addr = 7;
    #1;
    chk("t3_issue", {31'd0, a_issue}, 32'd1);
    step();
    chk("t3_busy7", a_busy, 32'h0000_0080);
    chk("t3_pend", {26'd0, a_pend}, 32'd1);
    write_addr = 0;
    #1;
    chk("t3_r0_issue", {31'd0, a_issue}, 32'd1);
    step();
    idle();
    chk("t3_r0_busy", a_busy, 32'd0);
    chk("t3_r0_pend", {26'd0, a_pend}, 32'd0);

    // 4: fill r3,r4,r9 then flush
    issue_write(3); issue_write(4); issue_write(9);
    chk("t4_busy", a_busy, 32'h0000_0218);
    chk("t4_pend", {26'd0, a_pend}, 32'd3);
    chk("t4_b_busy", b_busy, 32'h0000_0218);
    id_valid = 1; write_enable = 1; write_addr = 3; flush = 1;
    #1;
    chk("t4_fl_stall", {31'd0, a_stall}, 32'd0);
    chk("t4_fl_issue", {31'd0, a_issue}, 32'd0);
    step();
    idle();
    chk("t4_fl_busy", a_busy, 32'd0);
    chk("t4_fl_pend", {26'd0, a_pend}, 32'd0);
    chk("t4_fl_b_pend", {26'd0, b_pend}, 32'd0);

    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_a_sc", {16'd0, a_sc}, 32'd0);
    chk("mid_rst_b_sc", {28'd0, b_sc}, 32'd0);

    // 5: WAW on r6
    issue_write(6);
    id_valid = 1; write_enable = 1; write_addr = 6;
    #1;
    chk("t5_a_stall", {31'd0, a_stall}, 32'd1);
    chk("t5_b_stall", {31'd0, b_stall}, 32'd1);
    step();
    wb_valid = 1; wb_addr = 6;
    #1;
    chk("t5_wb_a_stall", {31'd0, a_stall}, 32'd0);
    chk("t5_wb_b_stall", {31'd0, b_stall}, 32'd1);
    chk("t5_wb_b_issue", {31'd0, b_issue}, 32'd0);
    step();
    wb_valid = 0; wb_addr = 0;
    chk("t5_a_busy", a_busy, 32'h0000_0040);
    chk("t5_b_busy", b_busy, 32'd0);
    #1;
    chk("t5_after_b_stall", {31'd0, b_stall}, 32'd0);
    chk("t5_after_b_issue", {31'd0, b_issue}, 32'd1);
    chk("t5_after_a_stall", {31'd0, a_stall}, 32'd1);
    step();
    chk("t5_b_busy2", b_busy, 32'h0000_0040);
    chk("t5_a_sc", {16'd0, a_sc}, 32'd2);
    chk("t5_b_sc", {28'd0, b_sc}, 32'd2);

    // 6: hold hazard 20 cycles; b saturates at 15
    for (int i = 0; i < 20; i++) step();
    chk("t6_b_sat", {28'd0, b_sc}, 32'd15);
    chk("t6_a_sc", {16'd0, a_sc}, 32'd22);
    rst = 1;
    #1;
    chk("t6_rst_stall", {31'd0, a_stall}, 32'd0);
    chk("t6_rst_issue", {31'd0, b_issue}, 32'd0);
    step();
    chk("t6_rst_busy", a_busy, 32'd0);
    chk("t6_rst_pend", {26'd0, b_pend}, 32'd0);
    chk("t6_rst_b_sc", {28'd0, b_sc}, 32'd0);
    chk("t6_rst_a_sc", {16'd0, a_sc}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
